// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: queue entry layout and fetch FSM states.
package fetch_unit_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;

   typedef logic [XLEN-1:0] word_t;

   typedef struct packed {
      word_t instr;
      word_t pc;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_FAULT
   } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with flush; push and pop may coincide at any fill level.
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          push_i,
   input  fetch_entry_t  entry_i,
   input  logic          pop_i,
   output fetch_entry_t  head_o,
   output logic [CW-1:0] count_o
);

   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   fetch_entry_t  mem_q [DEPTH];
   logic          do_push;
   logic          do_pop;

   // A push at full is only legal when the head leaves in the same cycle.
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= entry_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, issues word requests, queues in-order responses
// for decode and squashes in-flight responses on redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] instr_pc_plus4,
   output logic            fetch_fault
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned OW = CW + 1;

   fetch_state_e  state_q,       state_d;
   word_t         fetch_pc_q,    fetch_pc_d;
   word_t         resp_pc_q,     resp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] kill_q,        kill_d;

   logic [CW-1:0] q_count;
   fetch_entry_t  q_head;
   fetch_entry_t  q_entry;
   logic [OW-1:0] occupancy;
   logic          req_hs;
   logic          rsp_kill;
   logic          q_push;
   logic          q_pop;

   // Credit check counts both queued entries and requests still in flight.
   assign occupancy      = OW'(q_count) + OW'(outstanding_q);
   assign imem_req_valid = (state_q == S_RUN) && !redirect_valid && (occupancy < OW'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;

   assign req_hs   = imem_req_valid && imem_req_ready;
   assign rsp_kill = imem_rsp_valid && (kill_q != '0);
   assign q_push   = imem_rsp_valid && !rsp_kill && !redirect_valid;
   assign q_pop    = instr_valid && instr_ready && !redirect_valid;
   assign q_entry  = '{instr: imem_rsp_data, pc: resp_pc_q};

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_valid),
      .push_i  (q_push),
      .entry_i (q_entry),
      .pop_i   (q_pop),
      .head_o  (q_head),
      .count_o (q_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_BOOT;
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         kill_q        <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         kill_q        <= kill_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      kill_d        = kill_q;
      outstanding_d = outstanding_q + CW'(req_hs) - CW'(imem_rsp_valid);

      if (state_q == S_BOOT) state_d = S_RUN;
      if (req_hs)            fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
      if (rsp_kill)          kill_d = kill_q - CW'(1);
      if (q_push)            resp_pc_d = resp_pc_q + XLEN'(INSTR_BYTES);

      // Everything still in flight after this edge belongs to the old path.
      if (redirect_valid) begin
         kill_d    = outstanding_d;
         resp_pc_d = redirect_pc;
         if (redirect_pc[1:0] != 2'b00) begin
            state_d = S_FAULT;
         end else begin
            state_d    = S_RUN;
            fetch_pc_d = redirect_pc;
         end
      end
   end

   // Head fields read as zero while the queue is empty.
   assign instr_valid    = (q_count != '0);
   assign instr          = instr_valid ? q_head.instr : '0;
   assign instr_pc       = instr_valid ? q_head.pc : '0;
   assign instr_pc_plus4 = instr_valid ? (q_head.pc + XLEN'(INSTR_BYTES)) : '0;
   assign fetch_fault    = (state_q == S_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model, expected-stream scoreboard and decode-side monitor.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;
   logic        fetch_fault;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          t;
   } pend_t;

   exp_t        exp_q[$];
   pend_t       pend_q[$];
   logic [31:0] req_log[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   bit          mem_hold = 1'b0;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_pc_plus4 (instr_pc_plus4),
      .fetch_fault    (fetch_fault)
   );

   function automatic logic [31:0] memword(input logic [31:0] a);
      return a ^ 32'hC0DE_0013;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_range(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.pc  = base + 32'(4 * i);
         e.pc4 = base + 32'(4 * i + 4);
         exp_q.push_back(e);
      end
   endtask

   task automatic push_one(input logic [31:0] pc, input logic [31:0] pc4);
      exp_t e;
      e.pc  = pc;
      e.pc4 = pc4;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string name);
      instr_ready = 1'b1;
      for (int i = 0; i < 80 && exp_q.size() != 0; i++) step(1);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d entries left, want 0", name, exp_q.size());
         exp_q.delete();
      end
      instr_ready = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] pc);
      exp_q.delete();
      req_log.delete();
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      step(1);
      redirect_valid = 1'b0;
   endtask

   // Instruction memory: records handshakes mid-cycle, answers in order one cycle later.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst && imem_req_valid && imem_req_ready) begin
            pend_q.push_back('{addr: imem_req_addr, t: cyc});
            req_log.push_back(imem_req_addr);
         end
         @(posedge clk);
         cyc++;
         #1;
         if (rst) begin
            pend_q.delete();
            imem_rsp_valid = 1'b0;
         end else if (!mem_hold && pend_q.size() != 0 && cyc >= pend_q[0].t + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memword(pend_q[0].addr);
            void'(pend_q.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
         end
      end
   end

   // Decode-side monitor: every consumed instruction must match the next expected one.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && instr_valid && instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_instr: got pc %h, want no instruction", instr_pc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("instr_pc", instr_pc, e.pc);
               check("instr_pc_plus4", instr_pc_plus4, e.pc4);
               check("instr_word", instr, memword(e.pc));
            end
         end
      end
   end

   // Credit and kill invariants, plus responses with nothing outstanding.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (int'(dut.q_count) + int'(dut.outstanding_q) > int'(DEPTH)) begin
               n_checks++;
               n_fail++;
               $display("FAIL occupancy: got %0d, want <= %0d",
                        int'(dut.q_count) + int'(dut.outstanding_q), DEPTH);
            end
            if (dut.kill_q > dut.outstanding_q) begin
               n_checks++;
               n_fail++;
               $display("FAIL kill_bound: got kill %0d, want <= %0d", dut.kill_q, dut.outstanding_q);
            end
            if (imem_rsp_valid && dut.outstanding_q == '0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rsp_without_req: got response, want none");
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          viol;
      bit          found;
      logic [31:0] v;

      rst            = 1'b1;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b0;
      step(2);

      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_req_addr", imem_req_addr, 32'h0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_pc_plus4", instr_pc_plus4, 32'h0);
      check("rst_fault", 32'(fetch_fault), 32'd0);

      rst = 1'b0;
      #1;
      check("boot_idle", 32'(imem_req_valid), 32'd0);
      step(1);
      check("first_req_valid", 32'(imem_req_valid), 32'd1);
      check("first_req_addr", imem_req_addr, 32'h0);

      // Streaming with decode always ready.
      push_range(32'h0, 8);
      drain("stream");

      // Decode stall: queue fills and request issue stops.
      step(5);
      check("stall_req_valid", 32'(imem_req_valid), 32'd0);
      check("stall_instr_valid", 32'(instr_valid), 32'd1);
      push_range(32'h20, 8);
      drain("stall_release");

      // Two requests in flight, then redirect: both responses must be squashed.
      push_range(32'h40, 8);
      mem_hold    = 1'b1;
      instr_ready = 1'b1;
      step(6);
      check("hold_instr_valid", 32'(instr_valid), 32'd0);
      check("hold_req_valid", 32'(imem_req_valid), 32'd0);
      redirect(32'h100);
      push_range(32'h100, 8);
      mem_hold = 1'b0;
      drain("redirect_kill");

      // Misaligned target faults and stops fetch until an aligned redirect.
      redirect(32'h102);
      check("fault_set", 32'(fetch_fault), 32'd1);
      viol = 0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         if (imem_req_valid) viol++;
      end
      check("fault_no_req", 32'(viol), 32'd0);
      check("fault_sticky", 32'(fetch_fault), 32'd1);
      check("fault_no_instr", 32'(instr_valid), 32'd0);
      redirect(32'h200);
      check("fault_clear", 32'(fetch_fault), 32'd0);
      push_range(32'h200, 4);
      drain("fault_resume");

      // Redirect coinciding with a response and a pop.
      redirect(32'h280);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1);
         #1;
         if (instr_valid && imem_rsp_valid) found = 1'b1;
      end
      check("collision_found", 32'(found), 32'd1);
      exp_q.delete();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      instr_ready    = 1'b1;
      #1;
      check("collision_req_masked", 32'(imem_req_valid), 32'd0);
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      check("collision_flushed", 32'(instr_valid), 32'd0);
      push_range(32'h300, 4);
      drain("collision");

      // Address wrap at the top of memory.
      redirect(32'hFFFF_FFF8);
      push_one(32'hFFFF_FFF8, 32'hFFFF_FFFC);
      push_one(32'hFFFF_FFFC, 32'h0000_0000);
      push_one(32'h0000_0000, 32'h0000_0004);
      push_one(32'h0000_0004, 32'h0000_0008);
      drain("wrap");
      v = (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF;
      check("wrap_addr0", v, 32'hFFFF_FFF8);
      v = (req_log.size() > 1) ? req_log[1] : 32'hDEAD_BEEF;
      check("wrap_addr1", v, 32'hFFFF_FFFC);
      v = (req_log.size() > 2) ? req_log[2] : 32'hDEAD_BEEF;
      check("wrap_addr2", v, 32'h0000_0000);

      // Reset in the middle of traffic clears everything at once.
      step(4);
      mem_hold = 1'b1;
      rst      = 1'b1;
      #1;
      check("midrst_instr_valid", 32'(instr_valid), 32'd0);
      check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
      check("midrst_req_addr", imem_req_addr, 32'h0);
      check("midrst_fault", 32'(fetch_fault), 32'd0);
      step(2);
      mem_hold = 1'b0;

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
